// File: rtl/clint_timer_if.sv
// Data-memory bus seen by the CLINT timer: one request held until a single-cycle ack.
interface clint_timer_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, be, input rdata, ack);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/clint_timer.sv
// CLINT-style machine timer: 64-bit mtime/mtimecmp behind a bus slave, level-type
// timer_interrupt while mtime >= mtimecmp.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic         clk,
    input  logic         rst,
    clint_timer_if.slave bus,
    output logic         timer_interrupt
);
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [31:0] A_CMP_LO   = BASE_ADDR + 32'h0000_4000;
    localparam logic [31:0] A_CMP_HI   = BASE_ADDR + 32'h0000_4004;
    localparam logic [31:0] A_MT_LO    = BASE_ADDR + 32'h0000_BFF8;
    localparam logic [31:0] A_MT_HI    = BASE_ADDR + 32'h0000_BFFC;

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t      r_state, w_state_next;
    logic [63:0] r_mtime, r_mtimecmp;
    logic [63:0] w_mtime_next, w_mtimecmp_next;
    logic [15:0] r_presc, w_presc_next;
    logic [31:0] r_rdata, w_rdata_next;
    logic        r_irq;
    logic        w_accept, w_wr, w_tick;
    logic [31:0] w_bemask;

    // Handshake FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Handshake FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.req) w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake FSM: outputs
    always_comb begin
        bus.ack         = (r_state == ST_ACK);
        bus.rdata       = r_rdata;
        timer_interrupt = r_irq;
    end

    assign w_accept = bus.req && (r_state == ST_IDLE);
    assign w_wr     = w_accept && bus.we;
    assign w_bemask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};

    // A write to either mtime half starts from the pre-increment value, so the
    // tick is lost for the whole 64-bit word while the prescaler keeps running.
    always_comb begin
        w_tick          = (r_presc == PRESC_LAST);
        w_presc_next    = w_tick ? '0 : r_presc + 16'd1;
        w_mtime_next    = w_tick ? r_mtime + 64'd1 : r_mtime;
        w_mtimecmp_next = r_mtimecmp;
        if (w_wr) begin
            if (bus.addr == A_CMP_LO)
                w_mtimecmp_next = {r_mtimecmp[63:32],
                                   (r_mtimecmp[31:0] & ~w_bemask) | (bus.wdata & w_bemask)};
            else if (bus.addr == A_CMP_HI)
                w_mtimecmp_next = {(r_mtimecmp[63:32] & ~w_bemask) | (bus.wdata & w_bemask),
                                   r_mtimecmp[31:0]};
            else if (bus.addr == A_MT_LO)
                w_mtime_next = {r_mtime[63:32],
                                (r_mtime[31:0] & ~w_bemask) | (bus.wdata & w_bemask)};
            else if (bus.addr == A_MT_HI)
                w_mtime_next = {(r_mtime[63:32] & ~w_bemask) | (bus.wdata & w_bemask),
                                r_mtime[31:0]};
        end
    end

    always_comb begin
        w_rdata_next = '0;
        if (!bus.we) begin
            if      (bus.addr == A_CMP_LO) w_rdata_next = r_mtimecmp[31:0];
            else if (bus.addr == A_CMP_HI) w_rdata_next = r_mtimecmp[63:32];
            else if (bus.addr == A_MT_LO)  w_rdata_next = r_mtime[31:0];
            else if (bus.addr == A_MT_HI)  w_rdata_next = r_mtime[63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_presc    <= '0;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            r_presc    <= w_presc_next;
            if (w_accept) r_rdata <= w_rdata_next;
            r_irq      <= (w_mtime_next >= w_mtimecmp_next);
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// Directed and randomized checks of clint_timer (PRESCALE 1 and 4) against a
// cycle-count reference model of mtime.
module tb_clint_timer;
    localparam logic [31:0] BASE   = 32'h0200_0000;
    localparam logic [31:0] CMP_LO = BASE + 32'h4000;
    localparam logic [31:0] CMP_HI = BASE + 32'h4004;
    localparam logic [31:0] MT_LO  = BASE + 32'hBFF8;
    localparam logic [31:0] MT_HI  = BASE + 32'hBFFC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq1, irq4;

    clint_timer_if bi1();
    clint_timer_if bi4();

    clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bi1), .timer_interrupt(irq1));
    clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bi4), .timer_interrupt(irq4));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ecnt = number of clock edges since reset release = index of the next edge
    longint ecnt;
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    // Model: mtime = value written at edge m_edge plus the number of prescaler
    // ticks strictly after that edge; edge n ticks when n % P == P-1.
    logic [63:0] m_base [2];
    logic [63:0] m_cmp  [2];
    longint      m_edge [2];
    longint      m_p    [2];

    function automatic logic [63:0] mt_at(input int d, input longint r);
        return m_base[d] + 64'(r / m_p[d]) - 64'((m_edge[d] + 1) / m_p[d]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_base[d] = '0;
            m_cmp[d]  = '1;
            m_edge[d] = -1;
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a, input longint e);
        logic [63:0] t;
        t = mt_at(d, e);
        if (a == CMP_LO) return m_cmp[d][31:0];
        if (a == CMP_HI) return m_cmp[d][63:32];
        if (a == MT_LO)  return t[31:0];
        if (a == MT_HI)  return t[63:32];
        return 32'h0;
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] b, input longint e);
        logic [63:0] t;
        t = mt_at(d, e);
        if (a == CMP_LO)      m_cmp[d][31:0]  = merge(m_cmp[d][31:0], wd, b);
        else if (a == CMP_HI) m_cmp[d][63:32] = merge(m_cmp[d][63:32], wd, b);
        else if (a == MT_LO || a == MT_HI) begin
            if (a == MT_LO) t[31:0]  = merge(t[31:0], wd, b);
            else            t[63:32] = merge(t[63:32], wd, b);
            m_base[d] = t;
            m_edge[d] = e;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_irq(input int d);
        return (d == 0) ? irq1 : irq4;
    endfunction
    function automatic logic get_ack(input int d);
        return (d == 0) ? bi1.ack : bi4.ack;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? bi1.rdata : bi4.rdata;
    endfunction

    task automatic chk_irq(input int d);
        chk(d == 0 ? "irq_p1" : "irq_p4", 64'(get_irq(d)), 64'(mt_at(d, ecnt) >= m_cmp[d]));
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b);
        if (d == 0) begin
            bi1.req = r; bi1.we = w; bi1.addr = a; bi1.wdata = wd; bi1.be = b;
        end else begin
            bi4.req = r; bi4.we = w; bi4.addr = a; bi4.wdata = wd; bi4.be = b;
        end
    endtask

    // Entered and left at a falling edge.
    task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, output logic [31:0] rd);
        longint      e;
        logic [31:0] exp_r;
        drive(d, 1'b1, w, a, wd, b);
        e     = ecnt;
        exp_r = model_read(d, a, e);
        @(posedge clk);
        #1;
        if (w) model_write(d, a, wd, b, e);
        @(negedge clk);
        chk("ack_high", 64'(get_ack(d)), 64'd1);
        rd = get_rdata(d);
        if (!w) chk("rdata", 64'(rd), 64'(exp_r));
        chk_irq(d);
        drive(d, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("ack_low", 64'(get_ack(d)), 64'd0);
        chk_irq(d);
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_irq(d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [31:0] rd, w32;
    logic [63:0] v;
    int unsigned op;

    initial begin
        m_p[0] = 1;
        m_p[1] = 4;
        model_reset();
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ack1", 64'(bi1.ack), 64'd0);
        chk("rst_ack4", 64'(bi4.ack), 64'd0);
        chk("rst_irq1", 64'(irq1), 64'd0);
        chk("rst_rdata", 64'(bi1.rdata), 64'd0);
        acc(0, 1'b0, CMP_LO, '0, '0, rd);
        chk("cmp_lo_rst", 64'(rd), 64'hFFFF_FFFF);
        acc(0, 1'b0, CMP_HI, '0, '0, rd);
        chk("cmp_hi_rst", 64'(rd), 64'hFFFF_FFFF);

        // Carry from low word into high word
        acc(0, 1'b1, MT_LO, 32'hFFFF_FFFE, 4'hF, rd);
        acc(0, 1'b1, MT_HI, 32'h0, 4'hF, rd);
        acc(0, 1'b0, MT_HI, '0, '0, rd);
        chk("carry_hi", 64'(rd), 64'd1);

        // Compare crossing and deassert by raising mtimecmp
        acc(0, 1'b1, CMP_LO, 32'd100, 4'hF, rd);
        acc(0, 1'b1, CMP_HI, 32'd0, 4'hF, rd);
        acc(0, 1'b1, MT_HI, 32'd0, 4'hF, rd);
        acc(0, 1'b1, MT_LO, 32'd95, 4'hF, rd);
        idle(0, 10);
        chk("irq_high_after", 64'(irq1), 64'd1);
        acc(0, 1'b1, CMP_LO, 32'd1000, 4'hF, rd);
        chk("irq_fall", 64'(irq1), 64'd0);

        // Byte-enable write and unmapped access
        acc(0, 1'b1, CMP_LO, 32'hFFFF_FFFF, 4'hF, rd);
        acc(0, 1'b1, CMP_LO, 32'h0000_AB00, 4'b0010, rd);
        acc(0, 1'b0, CMP_LO, '0, '0, rd);
        chk("be_merge", 64'(rd), 64'hFFFF_ABFF);
        acc(0, 1'b1, BASE + 32'h8, 32'h1234_5678, 4'hF, rd);
        acc(0, 1'b0, BASE + 32'h8, '0, '0, rd);
        chk("unmapped_rd", 64'(rd), 64'd0);
        acc(0, 1'b0, CMP_LO, '0, '0, rd);

        // 64-bit wrap
        acc(0, 1'b1, MT_HI, 32'hFFFF_FFFF, 4'hF, rd);
        acc(0, 1'b1, MT_LO, 32'hFFFF_FFFF, 4'hF, rd);
        acc(0, 1'b0, MT_HI, '0, '0, rd);
        chk("wrap_hi", 64'(rd), 64'd0);
        acc(0, 1'b0, MT_LO, '0, '0, rd);

        // PRESCALE = 4 rate
        acc(1, 1'b1, MT_HI, 32'd0, 4'hF, rd);
        acc(1, 1'b1, MT_LO, 32'd0, 4'hF, rd);
        idle(1, 38);
        acc(1, 1'b0, MT_LO, '0, '0, rd);
        chk("presc_rate", 64'(rd >= 32'd9 && rd <= 32'd11), 64'd1);

        // Write to mtime on the increment edge keeps the written value
        for (int i = 0; i < 8; i++) begin
            if (ecnt % 4 == 3) break;
            @(negedge clk);
        end
        chk("tick_align", 64'(ecnt % 4), 64'd3);
        w32 = $urandom();
        acc(1, 1'b1, MT_LO, w32, 4'hF, rd);
        acc(1, 1'b0, MT_LO, '0, '0, rd);
        chk("wr_on_tick", 64'(rd), 64'(w32));

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 30; k++) begin
                op = $urandom_range(0, 4);
                case (op)
                    0: begin
                        v = mt_at(d, ecnt) + 64'($urandom_range(0, 40));
                        acc(d, 1'b1, CMP_HI, v[63:32], 4'hF, rd);
                        acc(d, 1'b1, CMP_LO, v[31:0], 4'hF, rd);
                    end
                    1: acc(d, 1'b1, ($urandom_range(0, 1) == 0) ? MT_LO : MT_HI, $urandom(),
                           4'($urandom_range(1, 15)), rd);
                    2: begin
                        case ($urandom_range(0, 3))
                            0: acc(d, 1'b0, CMP_LO, '0, '0, rd);
                            1: acc(d, 1'b0, CMP_HI, '0, '0, rd);
                            2: acc(d, 1'b0, MT_LO, '0, '0, rd);
                            default: acc(d, 1'b0, MT_HI, '0, '0, rd);
                        endcase
                    end
                    3: idle(d, int'($urandom_range(1, 6)));
                    default: acc(d, 1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 255) * 4),
                                 $urandom(), 4'hF, rd);
                endcase
            end
        end

        // Reset while an access is outstanding
        drive(0, 1'b1, 1'b1, CMP_LO, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", 64'(bi1.ack), 64'd0);
        chk("rst_mid_irq", 64'(irq1), 64'd0);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        acc(0, 1'b0, CMP_LO, '0, '0, rd);
        chk("rst_mid_cmp", 64'(rd), 64'hFFFF_FFFF);
        acc(0, 1'b0, MT_HI, '0, '0, rd);
        chk("rst_mid_mt_hi", 64'(rd), 64'd0);
        acc(0, 1'b0, MT_LO, '0, '0, rd);
        acc(1, 1'b0, MT_LO, '0, '0, rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
Memory-mapped machine timer, CLINT-style, with 64-bit mtime and mtimecmp registers.
Drives the timer_interrupt input of the CSR register file, which exposes it as mip.MTIP.
Sits on the data-memory bus as a slave. Software programs mtimecmp through load/store instructions.
No CSR-side logic lives here; masking by mie.MTIE and mstatus.MIE happens downstream.

Parameters:
BASE_ADDR, 32'h0200_0000, base of the CLINT window.
PRESCALE, 1, number of clk cycles per mtime increment; legal values 1 to 65535.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req  input  1  bus access request; held by master until ack
we  input  1  1 = write, 0 = read
addr  input  32  byte address, word-aligned
wdata  input  32  write data
be  input  4  byte enables for writes
rdata  output  32  read data; valid while ack = 1
ack  output  1  one-cycle access completion pulse
timer_interrupt  output  1  level-type interrupt, 1 while mtime >= mtimecmp

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
  - Any other address: reads return 0, writes are ignored, and ack is still given.
- Reset values (asynchronous):
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - prescale counter = 0
  - ack = 0, rdata = 0, timer_interrupt = 0
- Prescaler:
  - Counter runs 0 to PRESCALE-1. mtime increments by 1 in the cycle the counter equals PRESCALE-1, then the counter returns to 0.
  - With PRESCALE = 1, mtime increments every cycle.
- mtime arithmetic: full 64-bit unsigned. Carry propagates from the low word to the high word. 64'hFFFF_FFFF_FFFF_FFFF + 1 wraps to 0.
- Bus handshake:
  - An access is accepted in a cycle where req = 1 and ack = 0.
  - ack rises on the next edge and stays high for exactly one cycle; rdata is registered in the same edge.
  - With req held high continuously, accesses complete every 2 cycles.
  - Only one access is outstanding at a time; ack = 0 whenever no access is outstanding.
- Read data: the register value sampled at the accept edge, i.e. the pre-increment value of mtime in that cycle.
- Write: applied at the accept edge, per byte lane, where be[i] selects wdata[8i+7:8i]. be = 0 is a legal no-op write.
- Write to mtime in a cycle where the prescaler would also increment: the written bytes take the written value, and the increment is dropped for the whole 64-bit word in that cycle. The prescale counter continues unaffected.
- Comparison:
  - timer_interrupt is registered: timer_interrupt(next) = (mtime_next >= mtimecmp_next), 64-bit unsigned, evaluated on post-update values.
  - The interrupt therefore asserts in the same cycle mtime first equals mtimecmp.
  - Writing mtimecmp above mtime deasserts it one cycle after the write is accepted.
- Split 32-bit writes: the non-atomic low/high update window is software's responsibility; no shadow register.
- Reset mid-access: the outstanding access is dropped, ack = 0 immediately, and no partial write survives.

Test Plan:
- Reset, then read 0x4000 and 0x4004 → 32'hFFFF_FFFF each; timer_interrupt = 0; ack high exactly 1 cycle after req.
- PRESCALE = 1: write mtime_lo = 32'hFFFF_FFFE, mtime_hi = 0, then read mtime_hi after 3 cycles → 32'h0000_0001 (carry into high word).
- Write mtimecmp = 64'd100, mtime = 64'd95 → timer_interrupt rises on the cycle mtime reads 100 and stays high. Then write mtimecmp_lo = 1000 → timer_interrupt falls 1 cycle after ack.
- PRESCALE = 4: measure 40 cycles from mtime = 0 → mtime = 10 ± 1. Write to mtime coinciding with an increment edge → readback equals the written value exactly.
- Byte-enable write be = 4'b0010, wdata = 32'h0000_AB00 to mtimecmp_lo (was FFFF_FFFF) → readback 32'hFFFF_ABFF. Access to 0x0008 → ack pulses, rdata = 0, no state change.
- Set mtime = 64'hFFFF_FFFF_FFFF_FFFF → next increment gives mtime = 0. Assert rst while req is pending → ack = 0, and mtime and mtimecmp return to reset values.
